// File: rtl/decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module  : decode_issue_stage
// Brief   : In-order dual-issue decode stage with a per-register scoreboard.
//           Optional macro FORWARDING_EN: bypass from the last pipe stage.
// Rev     : 1.0  initial release
// ============================================================================
// Instruction bit k in big-endian numbering lives at [31-k]: opcode inst[0:10]
// is [31:21], rb [20:14], ra [13:7], rt [6:0].
module decode_issue_stage #(
  parameter int LAT_EVEN = 6,
  parameter int LAT_ODD  = 4,
  parameter int NUM_REGS = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] first_inst,
  input  logic [31:0] second_inst,
  output logic        stall,
  output logic [31:0] even_inst,
  output logic        even_valid,
  output logic [31:0] odd_inst,
  output logic        odd_valid,
  output logic        halted
);

  localparam int LAT_MAX = (LAT_EVEN > LAT_ODD) ? LAT_EVEN : LAT_ODD;
  localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [CW-1:0] SET_EVEN = CW'(LAT_EVEN - 1);
  localparam logic [CW-1:0] SET_ODD  = CW'(LAT_ODD - 1);

  typedef enum logic [1:0] {
    FRESH       = 2'd0,
    SECOND_ONLY = 2'd1,
    HALT        = 2'd2
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_sb [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
`ifdef FORWARDING_EN
      assign w_busy[gi] = (r_sb[gi] > CW'(1));
`else
      assign w_busy[gi] = (r_sb[gi] != '0);
`endif
    end
  endgenerate

  logic       w_f_stop, w_f_nop, w_f_real, w_f_odd;
  logic       w_s_stop, w_s_nop, w_s_real, w_s_odd;
  logic [6:0] w_f_rt, w_f_ra, w_f_rb, w_s_rt, w_s_ra, w_s_rb;
  logic       w_f_sbhaz, w_s_sbhaz, w_s_raw, w_s_struct;

  assign w_f_stop = (first_inst[31:21] == 11'b00000000000);
  assign w_f_nop  = (first_inst[31:21] == 11'b00000000001) || (first_inst[31:21] == 11'b01000000001);
  assign w_f_real = !w_f_stop && !w_f_nop;
  assign w_f_odd  = (first_inst[31:28] == 4'b0011);
  assign w_s_stop = (second_inst[31:21] == 11'b00000000000);
  assign w_s_nop  = (second_inst[31:21] == 11'b00000000001) || (second_inst[31:21] == 11'b01000000001);
  assign w_s_real = !w_s_stop && !w_s_nop;
  assign w_s_odd  = (second_inst[31:28] == 4'b0011);

  assign w_f_rt = first_inst[6:0];
  assign w_f_ra = first_inst[13:7];
  assign w_f_rb = first_inst[20:14];
  assign w_s_rt = second_inst[6:0];
  assign w_s_ra = second_inst[13:7];
  assign w_s_rb = second_inst[20:14];

  // Stop and no-ops carry no operands, so they never see a register hazard.
  assign w_f_sbhaz  = w_f_real && (w_busy[w_f_rt] || w_busy[w_f_ra] || w_busy[w_f_rb]);
  assign w_s_sbhaz  = w_s_real && (w_busy[w_s_rt] || w_busy[w_s_ra] || w_busy[w_s_rb]);
  assign w_s_raw    = w_f_real && w_s_real &&
                      ((w_s_rt == w_f_rt) || (w_s_ra == w_f_rt) || (w_s_rb == w_f_rt));
  assign w_s_struct = w_f_real && w_s_real && (w_f_odd == w_s_odd);

  logic w_iss_first, w_iss_second;

  always_comb begin
    w_iss_first  = 1'b0;
    w_iss_second = 1'b0;
    stall        = 1'b0;
    if (!reset) begin
      case (r_state)
        HALT: stall = 1'b1;
        SECOND_ONLY: begin
          if (!flush) begin
            w_iss_second = !w_s_sbhaz;
            stall        = !w_iss_second;
          end
        end
        default: begin
          if (!flush) begin
            w_iss_first  = !w_f_sbhaz;
            w_iss_second = w_iss_first && !w_f_stop && !w_s_sbhaz && !w_s_raw && !w_s_struct;
            stall        = !w_iss_second;
          end
        end
      endcase
    end
  end

  logic          w_f_even_go, w_f_odd_go, w_s_even_go, w_s_odd_go, w_halt_go;
  logic          w_f_set, w_s_set;
  logic [CW-1:0] w_f_lat, w_s_lat;

  assign w_f_even_go = w_iss_first  && w_f_real && !w_f_odd;
  assign w_f_odd_go  = w_iss_first  && w_f_real &&  w_f_odd;
  assign w_s_even_go = w_iss_second && w_s_real && !w_s_odd;
  assign w_s_odd_go  = w_iss_second && w_s_real &&  w_s_odd;
  assign w_halt_go   = (w_iss_first && w_f_stop) || (w_iss_second && w_s_stop);
  assign w_f_set     = w_iss_first  && w_f_real;
  assign w_s_set     = w_iss_second && w_s_real;
  assign w_f_lat     = w_f_odd ? SET_ODD : SET_EVEN;
  assign w_s_lat     = w_s_odd ? SET_ODD : SET_EVEN;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= FRESH;
      even_inst  <= '0;
      even_valid <= 1'b0;
      odd_inst   <= '0;
      odd_valid  <= 1'b0;
      halted     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_sb[i] <= '0;
    end else begin
      even_valid <= w_f_even_go || w_s_even_go;
      odd_valid  <= w_f_odd_go  || w_s_odd_go;
      if (w_f_even_go)      even_inst <= first_inst;
      else if (w_s_even_go) even_inst <= second_inst;
      if (w_f_odd_go)       odd_inst  <= first_inst;
      else if (w_s_odd_go)  odd_inst  <= second_inst;

      if (w_halt_go) begin
        r_state <= HALT;
        halted  <= 1'b1;
      end else if (r_state != HALT) begin
        if (flush)                                              r_state <= FRESH;
        else if (r_state == SECOND_ONLY && w_iss_second)        r_state <= FRESH;
        else if (r_state == FRESH && w_iss_first && !w_iss_second) r_state <= SECOND_ONLY;
      end

      // A pair never issues two writers of the same rt, so the order here is moot.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_f_set && (w_f_rt == 7'(i)))      r_sb[i] <= w_f_lat;
        else if (w_s_set && (w_s_rt == 7'(i))) r_sb[i] <= w_s_lat;
        else if (r_sb[i] != '0)                r_sb[i] <= r_sb[i] - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire
